// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the data-memory access controller.
// Used by mem_access_ctrl and load_formatter.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam int         LANE_W   = 2;

  function automatic logic [3:0] lane_be(
    input logic              is_byte,
    input logic [LANE_W-1:0] lane
  );
    return is_byte ? (BE_BYTE0 << lane) : BE_WORD;
  endfunction

endpackage

// File: rtl/load_formatter.sv
// Formats raw memory read data into the load result.
// Byte loads pick one lane and zero-fill; word loads pass through.
module load_formatter
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [LANE_W-1:0] lane,
  input  logic              is_byte,
  output logic [DATA_W-1:0] fmt
);

  logic [7:0] sel;

  // Select the addressed byte lane and zero-extend for lbu
  always_comb begin
    sel = rdata[{lane, 3'b000} +: 8];
    fmt = is_byte ? {{(DATA_W-8){1'b0}}, sel} : rdata;
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Data-memory access sequencer: IDLE -> ACCESS -> RESP.
// Optional MISALIGN_CHECK_EN flags misaligned word accesses.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              busy
);

  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t            state;
  state_t            state_nx;
  logic [3:0]        cnt;
  logic              we_q;
  logic              byte_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] fmt;
  logic              accept;

`ifdef MISALIGN_CHECK_EN
  logic misalign;
  logic err_q;

  assign misalign = !req_byte && (req_addr[1:0] != 2'b00);
`endif

  assign accept    = req_valid && req_ready;
  assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
  assign resp_data = rdata_q;

  load_formatter #(
    .DATA_W(DATA_W)
  ) u_fmt (
    .rdata  (mem_rdata),
    .lane   (addr_q[LANE_W-1:0]),
    .is_byte(byte_q),
    .fmt    (fmt)
  );

  // State register
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and memory/response outputs
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    busy       = 1'b1;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_wdata  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
`ifdef MISALIGN_CHECK_EN
          state_nx = misalign ? RESP : ACCESS;
`else
          state_nx = ACCESS;
`endif
        end
      end
      ACCESS: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_be    = lane_be(byte_q, addr_q[LANE_W-1:0]);
        mem_wdata = byte_q ? {(DATA_W/8){wdata_q[7:0]}}
                           : wdata_q;
        if (cnt == LAST) state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
`ifdef MISALIGN_CHECK_EN
        resp_err   = err_q;
`endif
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latch, wait counter and response capture
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else if (accept) begin
      cnt     <= '0;
      we_q    <= req_we;
      byte_q  <= req_byte;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      rdata_q <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 4'd1;
      if (cnt == LAST) rdata_q <= we_q ? '0 : fmt;
    end
  end

`ifdef MISALIGN_CHECK_EN
  // Error flag for the pending response
  always_ff @(posedge Clk) begin
    if (Rst)         err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl.
// Randomized accesses compared to a spec-level model.
module tb_mem_access_ctrl;

  localparam int WC = 2;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        req_valid, req_ready, req_we, req_byte;
  logic [31:0] req_addr, req_wdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_data;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(
    .DATA_W(32), .ADDR_W(32), .WAIT_CYCLES(WC)
  ) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_err(resp_err), .busy(busy)
  );

  typedef struct packed {
    int          en_cnt;
    int          resp_cyc;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        we;
    logic        err;
  } exp_t;

  // Expected behaviour of one access, from the access rules
  function automatic exp_t model(input logic we, input logic byt,
                                 input logic [31:0] addr,
                                 input logic [31:0] wdata,
                                 input logic [31:0] rdata);
    exp_t m;
    int   lane;
    bit   mis;
    lane = int'(addr % 4);
    mis  = 0;
`ifdef MISALIGN_CHECK_EN
    mis = !byt && lane != 0;
`endif
    m = '0;
    if (mis) begin
      m.en_cnt   = 0;
      m.resp_cyc = 1;
      m.err      = 1'b1;
      m.rdata    = 32'h0;
    end else begin
      m.en_cnt   = WC;
      m.resp_cyc = WC + 1;
      m.addr     = addr - (addr % 4);
      m.be       = byt ? 4'(1 << lane) : 4'hF;
      m.wdata    = byt ? (wdata & 32'hFF) * 32'h01010101 : wdata;
      m.we       = we;
      m.err      = 1'b0;
      if (we)       m.rdata = 32'h0;
      else if (byt) m.rdata = (rdata >> (8 * lane)) & 32'hFF;
      else          m.rdata = rdata;
    end
    return m;
  endfunction

  bit          ob_acc;
  int          ob_en_cnt, ob_we_cnt, ob_first_en, ob_resp_cyc, ob_bad;
  logic [3:0]  ob_be;
  logic [31:0] ob_addr, ob_wdata, ob_rd;
  logic        ob_we, ob_err;

  // Drive one request and record what the DUT does with it
  task automatic run_txn(input logic we, input logic byt,
                         input logic [31:0] addr,
                         input logic [31:0] wdata,
                         input logic [31:0] rdata);
    @(negedge Clk);
    req_we = we; req_byte = byt; req_addr = addr;
    req_wdata = wdata; mem_rdata = rdata; req_valid = 1'b1;
    ob_acc = 0; ob_en_cnt = 0; ob_we_cnt = 0; ob_first_en = 0;
    ob_resp_cyc = 0; ob_bad = 0; ob_be = 'x; ob_addr = 'x;
    ob_wdata = 'x; ob_rd = 'x; ob_we = 'x; ob_err = 'x;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin
        ob_acc = 1;
        break;
      end
      @(negedge Clk);
    end
    @(negedge Clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (mem_en) begin
        ob_en_cnt++;
        if (mem_we) ob_we_cnt++;
        if (ob_first_en == 0) ob_first_en = k;
        ob_be = mem_be; ob_addr = mem_addr;
        ob_wdata = mem_wdata; ob_we = mem_we;
      end else if (mem_we || mem_be != 0 || mem_wdata != 0) begin
        ob_bad++;
      end
      if (req_ready && busy) ob_bad++;
      if (resp_valid) begin
        ob_resp_cyc = k; ob_rd = resp_data; ob_err = resp_err;
        break;
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    checks++;
    if ({req_ready, mem_en, mem_we, resp_valid, resp_err, busy}
        !== 6'b100000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 100000",
               {req_ready, mem_en, mem_we, resp_valid, resp_err, busy});
    end
    checks++;
    if ({mem_be, mem_addr, mem_wdata, resp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: be=%h addr=%h wd=%h rd=%h expected 0",
               mem_be, mem_addr, mem_wdata, resp_data);
    end
    Rst = 1'b0;
  endtask

  task automatic test_lw();
    run_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF);
    checks++;
    if (ob_acc !== 1'b1) begin
      errors++; $display("FAIL lw_accept: got %0d expected 1", ob_acc);
    end
    checks++;
    if (ob_first_en !== 1) begin
      errors++; $display("FAIL lw_first_en: got %0d expected 1", ob_first_en);
    end
    checks++;
    if (ob_en_cnt !== WC) begin
      errors++; $display("FAIL lw_en_cycles: got %0d expected %0d", ob_en_cnt, WC);
    end
    checks++;
    if (ob_resp_cyc !== WC + 1) begin
      errors++; $display("FAIL lw_resp_cycle: got %0d expected %0d", ob_resp_cyc, WC + 1);
    end
    checks++;
    if (ob_rd !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_data: got %h expected deadbeef", ob_rd);
    end
    checks++;
    if ({ob_be, ob_we} !== 5'b11110) begin
      errors++; $display("FAIL lw_be_we: got %b expected 11110", {ob_be, ob_we});
    end
    checks++;
    if (ob_addr !== 32'h10) begin
      errors++; $display("FAIL lw_addr: got %h expected 10", ob_addr);
    end
    checks++;
    if (ob_bad !== 0) begin
      errors++; $display("FAIL lw_idle_outputs: got %0d expected 0", ob_bad);
    end
  endtask

  task automatic test_lbu();
    run_txn(1'b0, 1'b1, 32'h13, 32'h0, 32'hA1B2C3D4);
    checks++;
    if (ob_addr !== 32'h10) begin
      errors++; $display("FAIL lbu_addr: got %h expected 10", ob_addr);
    end
    checks++;
    if (ob_rd !== 32'h000000A1) begin
      errors++; $display("FAIL lbu_data: got %h expected 000000a1", ob_rd);
    end
    checks++;
    if (ob_resp_cyc !== WC + 1) begin
      errors++; $display("FAIL lbu_resp_cycle: got %0d expected %0d", ob_resp_cyc, WC + 1);
    end
  endtask

  task automatic test_sb();
    run_txn(1'b1, 1'b1, 32'h21, 32'h000000EE, 32'h12345678);
    checks++;
    if (ob_be !== 4'b0010) begin
      errors++; $display("FAIL sb_be: got %b expected 0010", ob_be);
    end
    checks++;
    if (ob_wdata !== 32'hEEEEEEEE) begin
      errors++; $display("FAIL sb_wdata: got %h expected eeeeeeee", ob_wdata);
    end
    checks++;
    if (ob_we_cnt !== WC) begin
      errors++; $display("FAIL sb_we_cycles: got %0d expected %0d", ob_we_cnt, WC);
    end
    checks++;
    if (ob_rd !== 32'h0) begin
      errors++; $display("FAIL sb_resp_data: got %h expected 0", ob_rd);
    end
    checks++;
    if (ob_addr !== 32'h20) begin
      errors++; $display("FAIL sb_addr: got %h expected 20", ob_addr);
    end
  endtask

  task automatic test_back_to_back();
    int acc[$];
    int bad;
    int rc;
    int d;
    bad = 0; rc = 0;
    @(negedge Clk);
    req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h40;
    req_wdata = 32'h0; mem_rdata = 32'h55AA55AA; req_valid = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (req_ready) acc.push_back(c);
      if (req_ready && busy) bad++;
      if (resp_valid) rc++;
      @(negedge Clk);
    end
    req_valid = 1'b0;
    for (int i = 0; i < 20 && busy; i++) @(negedge Clk);
    d = (acc.size() >= 2) ? acc[1] - acc[0] : -1;
    checks++;
    if (d !== WC + 2) begin
      errors++; $display("FAIL b2b_spacing: got %0d expected %0d", d, WC + 2);
    end
    checks++;
    if (acc.size() !== 4) begin
      errors++; $display("FAIL b2b_accepts: got %0d expected 4", acc.size());
    end
    checks++;
    if (rc !== 3) begin
      errors++; $display("FAIL b2b_responses: got %0d expected 3", rc);
    end
    checks++;
    if (bad !== 0) begin
      errors++; $display("FAIL b2b_ready_busy: got %0d expected 0", bad);
    end
  endtask

  task automatic test_reset_abort();
    int rv;
    rv = 0;
    @(negedge Clk);
    req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h80;
    req_wdata = 32'hCAFEF00D; req_valid = 1'b1;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge Clk);
    @(negedge Clk);
    req_valid = 1'b0;
    checks++;
    if ({mem_en, mem_we} !== 2'b11) begin
      errors++; $display("FAIL abort_access: got %b expected 11", {mem_en, mem_we});
    end
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    checks++;
    if ({busy, mem_en, mem_we, req_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL abort_idle: got %b expected 0001",
               {busy, mem_en, mem_we, req_ready});
    end
    for (int i = 0; i < 6; i++) begin
      if (resp_valid) rv++;
      @(negedge Clk);
    end
    checks++;
    if (rv !== 0) begin
      errors++; $display("FAIL abort_no_resp: got %0d expected 0", rv);
    end
  endtask

  task automatic test_misalign();
    exp_t e;
    e = model(1'b0, 1'b0, 32'h22, 32'h0, 32'h0BADC0DE);
    run_txn(1'b0, 1'b0, 32'h22, 32'h0, 32'h0BADC0DE);
    checks++;
    if (ob_en_cnt !== e.en_cnt) begin
      errors++; $display("FAIL mis_en_cycles: got %0d expected %0d", ob_en_cnt, e.en_cnt);
    end
    checks++;
    if (ob_resp_cyc !== e.resp_cyc) begin
      errors++; $display("FAIL mis_resp_cycle: got %0d expected %0d", ob_resp_cyc, e.resp_cyc);
    end
    checks++;
    if (ob_err !== e.err) begin
      errors++; $display("FAIL mis_err: got %b expected %b", ob_err, e.err);
    end
    checks++;
    if (ob_rd !== e.rdata) begin
      errors++; $display("FAIL mis_data: got %h expected %h", ob_rd, e.rdata);
    end
  endtask

  task automatic test_random();
    exp_t        e;
    logic        we, byt;
    logic [31:0] addr, wd, rd;
    for (int n = 0; n < 40; n++) begin
      we = 1'($urandom); byt = 1'($urandom);
      addr = $urandom; wd = $urandom; rd = $urandom;
      e = model(we, byt, addr, wd, rd);
      run_txn(we, byt, addr, wd, rd);
      checks++;
      if (ob_en_cnt !== e.en_cnt || ob_resp_cyc !== e.resp_cyc) begin
        errors++;
        $display("FAIL rnd_timing[%0d]: got en=%0d resp=%0d expected en=%0d resp=%0d",
                 n, ob_en_cnt, ob_resp_cyc, e.en_cnt, e.resp_cyc);
      end
      checks++;
      if (ob_rd !== e.rdata || ob_err !== e.err) begin
        errors++;
        $display("FAIL rnd_resp[%0d]: got %h/%b expected %h/%b",
                 n, ob_rd, ob_err, e.rdata, e.err);
      end
      checks++;
      if (ob_bad !== 0) begin
        errors++; $display("FAIL rnd_idle_outputs[%0d]: got %0d expected 0", n, ob_bad);
      end
      if (e.en_cnt > 0) begin
        checks++;
        if ({ob_be, ob_we, ob_addr} !== {e.be, e.we, e.addr}) begin
          errors++;
          $display("FAIL rnd_port[%0d]: got be=%b we=%b a=%h expected be=%b we=%b a=%h",
                   n, ob_be, ob_we, ob_addr, e.be, e.we, e.addr);
        end
        checks++;
        if (ob_wdata !== e.wdata) begin
          errors++;
          $display("FAIL rnd_wdata[%0d]: got %h expected %h", n, ob_wdata, e.wdata);
        end
      end
    end
  endtask

  initial begin
    Rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_byte = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0;
    test_reset();
    test_lw();
    test_lbu();
    test_sb();
    test_back_to_back();
    test_reset_abort();
    test_misalign();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
